// File: rtl/seg_scan_controller_if.sv
// seg_scan_controller_if
//   Groups the display-data inputs and the multiplexed display outputs of
//   seg_scan_controller into one bundle.
//   digits_in  : 32  hex nibble per digit, digit i = digits_in[4i+3:4i]
//   dp_in      : 8   decimal point request per digit, 1 = lit
//   digit_en   : 8   per-digit enable, 1 = digit may be lit
//   AN         : 8   anode select, active-low one-hot or all-ones
//   SEG        : 7   cathodes {g,f,e,d,c,b,a}, active-low
//   DP         : 1   decimal-point cathode, active-low
//   frame_done : 1   one-clock pulse at the start of each new scan frame
//   master modport drives the data inputs, slave modport is the controller.
interface seg_scan_controller_if;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_done;

  modport master (
    output digits_in, dp_in, digit_en,
    input  AN, SEG, DP, frame_done
  );

  modport slave (
    input  digits_in, dp_in, digit_en,
    output AN, SEG, DP, frame_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Time-multiplexed 7-segment scanner. Each digit slot is an all-off
//   BLANK period of BLANK_CYCLES clocks followed by a DRIVE period of
//   DRIVE_CYCLES clocks. Digit data and decimal points are shadowed once
//   per frame so a frame always shows a consistent snapshot.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : seg_scan_controller_if.slave (digits_in, dp_in, digit_en in;
//          AN, SEG, DP, frame_done out)
//   NUM_DIGITS   : scanned digit positions, 1..8
//   DRIVE_CYCLES : clocks each digit is driven, >= 1
//   BLANK_CYCLES : dead-time clocks before each digit, >= 0
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int DRIVE_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_controller_if.slave  bus
);

  localparam int MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DRV_LAST = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam state_t START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t        state, nxt_state;
  logic [2:0]    idx, nxt_idx;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [31:0]   sh_d, nxt_sh_d;
  logic [7:0]    sh_dp, nxt_sh_dp;
  logic          frame_end;
  logic [3:0]    nibble;
  logic [7:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt + CW'(1);
    frame_end = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLK_LAST) begin
          nxt_state = DRIVE;
          nxt_cnt   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DRV_LAST) begin
          nxt_cnt   = '0;
          nxt_state = START;
          if (idx == IDX_LAST) begin
            nxt_idx   = '0;
            frame_end = 1'b1;
          end else begin
            nxt_idx = idx + 3'd1;
          end
        end
      end
      default: ;
    endcase

    nxt_sh_d  = frame_end ? bus.digits_in : sh_d;
    nxt_sh_dp = frame_end ? bus.dp_in     : sh_dp;

    // Outputs are decoded from the next state and next shadow so the
    // registered pins line up with the cycle the state register holds them.
    nibble = nxt_sh_d[{nxt_idx, 2'b00} +: 4];
    an_n   = '1;
    seg_n  = '1;
    dp_n   = 1'b1;
    if (nxt_state == DRIVE && bus.digit_en[nxt_idx]) begin
      an_n  = ~(8'b1 << nxt_idx);
      seg_n = hex7(nibble);
      dp_n  = ~nxt_sh_dp[nxt_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= START;
      idx            <= '0;
      cnt            <= '0;
      sh_d           <= '0;
      sh_dp          <= '0;
      bus.AN         <= '1;
      bus.SEG        <= '1;
      bus.DP         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= nxt_state;
      idx            <= nxt_idx;
      cnt            <= nxt_cnt;
      sh_d           <= nxt_sh_d;
      sh_dp          <= nxt_sh_dp;
      bus.AN         <= an_n;
      bus.SEG        <= seg_n;
      bus.DP         <= dp_n;
      bus.frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller
//   Bench for seg_scan_controller with two configurations:
//   dut_a: NUM_DIGITS=4, DRIVE=4, BLANK=2 (24-clock frame)
//   dut_b: NUM_DIGITS=1, DRIVE=1, BLANK=0 (1-clock frame)
//   Expected outputs come from a frame-position model: cycle t after reset
//   release maps to slot t%frame/(blank+drive), and the displayed data is
//   the snapshot of the inputs taken at the previous frame boundary.
module tb_seg_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  seg_scan_controller_if ifa ();
  seg_scan_controller_if ifb ();

  seg_scan_controller #(.NUM_DIGITS(4), .DRIVE_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  seg_scan_controller #(.NUM_DIGITS(1), .DRIVE_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Returns {AN, SEG, DP, frame_done} expected in cycle t after reset release.
  function automatic logic [16:0] model(input int n, input int d, input int b, input int t,
                                        input logic [7:0] en, input logic [31:0] sd,
                                        input logic [7:0] sdp);
    int         fl, p, slot, w;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp, fd;
    fl  = n * (b + d);
    an  = 8'hFF;
    seg = 7'h7F;
    dp  = 1'b1;
    fd  = (t > 0) && (t % fl == 0);
    if (t > 0) begin
      p    = t % fl;
      slot = p / (b + d);
      w    = p % (b + d);
      if (w >= b && en[slot]) begin
        an[slot] = 1'b0;
        seg      = hex_tbl[sd[slot*4 +: 4]];
        dp       = ~sdp[slot];
      end
    end
    return {an, seg, dp, fd};
  endfunction

  logic [16:0] obs_a, obs_b, exp_v;
  assign obs_a = {ifa.AN, ifa.SEG, ifa.DP, ifa.frame_done};
  assign obs_b = {ifb.AN, ifb.SEG, ifb.DP, ifb.frame_done};

  logic [31:0] sd;
  logic [7:0]  sdp;

  // Holds dut_a in reset for two cycles, releases on a falling edge.
  task automatic reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    sd    = '0;
    sdp   = '0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    checks++;
    if (obs_a !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_a got %h want %h", obs_a, {8'hFF, 7'h7F, 1'b1, 1'b0});
    if (obs_a !== {8'hFF, 7'h7F, 1'b1, 1'b0}) errors++;
    checks++;
    if (obs_b !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      $display("FAIL reset_b got %h want %h", obs_b, {8'hFF, 7'h7F, 1'b1, 1'b0});
      errors++;
    end
    reset_a();
    checks++;
    exp_v = model(4, 4, 2, 0, ifa.digit_en, sd, sdp);
    if (obs_a !== exp_v) begin
      $display("FAIL reset_release got %h want %h", obs_a, exp_v);
      errors++;
    end
  endtask

  // Fixed A810 held across frames, all digits enabled.
  task automatic test_frame_fixed();
    ifa.digits_in = 32'h0000_A810;
    ifa.dp_in     = 8'h00;
    ifa.digit_en  = 8'hFF;
    reset_a();
    for (int t = 1; t <= 60; t++) begin
      @(posedge clk);
      #1;
      if (t % 24 == 0) begin sd = ifa.digits_in; sdp = ifa.dp_in; end
      exp_v = model(4, 4, 2, t, ifa.digit_en, sd, sdp);
      checks++;
      if (obs_a !== exp_v) begin
        $display("FAIL frame_fixed t=%0d got %h want %h", t, obs_a, exp_v);
        errors++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_digit_en();
    ifa.digits_in = $urandom;
    ifa.dp_in     = 8'($urandom);
    ifa.digit_en  = 8'b0000_0101;
    reset_a();
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk);
      #1;
      if (t % 24 == 0) begin sd = ifa.digits_in; sdp = ifa.dp_in; end
      exp_v = model(4, 4, 2, t, ifa.digit_en, sd, sdp);
      checks++;
      if (obs_a !== exp_v) begin
        $display("FAIL digit_en t=%0d got %h want %h", t, obs_a, exp_v);
        errors++;
      end
      @(negedge clk);
    end
  endtask

  // Inputs change every cycle; only the boundary snapshot may show.
  task automatic test_random();
    logic [31:0] din;
    logic [7:0]  dpin, en;
    ifa.digit_en = 8'hFF;
    reset_a();
    for (int t = 1; t <= 400; t++) begin
      din           = $urandom;
      dpin          = 8'($urandom);
      ifa.digits_in = din;
      ifa.dp_in     = dpin;
      if (t % 7 == 0) ifa.digit_en = 8'($urandom);
      en = ifa.digit_en;
      @(posedge clk);
      #1;
      if (t % 24 == 0) begin sd = din; sdp = dpin; end
      exp_v = model(4, 4, 2, t, en, sd, sdp);
      checks++;
      if (obs_a !== exp_v) begin
        $display("FAIL random t=%0d got %h want %h", t, obs_a, exp_v);
        errors++;
      end
      @(negedge clk);
    end
  endtask

  // Reset during DRIVE of digit 2 after a shadow load of non-zero data.
  task automatic test_async_reset();
    ifa.digits_in = 32'h1234_5678;
    ifa.dp_in     = 8'hFF;
    ifa.digit_en  = 8'hFF;
    reset_a();
    for (int t = 1; t <= 39; t++) begin
      @(posedge clk);
      #1;
      if (t % 24 == 0) begin sd = ifa.digits_in; sdp = ifa.dp_in; end
      exp_v = model(4, 4, 2, t, ifa.digit_en, sd, sdp);
      checks++;
      if (obs_a !== exp_v) begin
        $display("FAIL pre_reset t=%0d got %h want %h", t, obs_a, exp_v);
        errors++;
      end
    end
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if (obs_a !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      $display("FAIL async_reset got %h want %h", obs_a, {8'hFF, 7'h7F, 1'b1, 1'b0});
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    sd    = '0;
    sdp   = '0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk);
      #1;
      if (t % 24 == 0) begin sd = ifa.digits_in; sdp = ifa.dp_in; end
      exp_v = model(4, 4, 2, t, ifa.digit_en, sd, sdp);
      checks++;
      if (obs_a !== exp_v) begin
        $display("FAIL post_reset t=%0d got %h want %h", t, obs_a, exp_v);
        errors++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_digit();
    logic [31:0] din;
    logic [7:0]  dpin, en;
    ifb.digits_in = '0;
    ifb.dp_in     = '0;
    ifb.digit_en  = 8'h01;
    sd            = '0;
    sdp           = '0;
    @(negedge clk);
    rst_b = 1'b0;
    checks++;
    exp_v = model(1, 1, 0, 0, ifb.digit_en, sd, sdp);
    if (obs_b !== exp_v) begin
      $display("FAIL single_release got %h want %h", obs_b, exp_v);
      errors++;
    end
    for (int t = 1; t <= 30; t++) begin
      din           = $urandom;
      dpin          = 8'($urandom);
      ifb.digits_in = din;
      ifb.dp_in     = dpin;
      ifb.digit_en  = (t > 20) ? 8'($urandom) : 8'h01;
      en            = ifb.digit_en;
      @(posedge clk);
      #1;
      sd  = din;
      sdp = dpin;
      exp_v = model(1, 1, 0, t, en, sd, sdp);
      checks++;
      if (obs_b !== exp_v) begin
        $display("FAIL single_digit t=%0d got %h want %h", t, obs_b, exp_v);
        errors++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    ifa.digits_in = '0;
    ifa.dp_in     = '0;
    ifa.digit_en  = 8'hFF;
    ifb.digits_in = '0;
    ifb.dp_in     = '0;
    ifb.digit_en  = 8'h01;
    sd            = '0;
    sdp           = '0;
    test_reset();
    test_frame_fixed();
    test_digit_en();
    test_random();
    test_async_reset();
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of scanned digit positions, legal range 1..8.
REQ-002 Parameter DRIVE_CYCLES, default 100000: clocks each digit is driven, legal range >= 1.
REQ-003 Parameter BLANK_CYCLES, default 1000: all-off dead-time clocks before each digit, legal range >= 0.
REQ-004 clk  input  1  system clock; the block SHALL use this single clock only.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 digits_in  input  32  hex nibble per digit; digit i = digits_in[4i+3:4i].
REQ-007 dp_in  input  8  decimal point request per digit, 1 = lit.
REQ-008 digit_en  input  8  per-digit enable, 1 = digit may be lit.
REQ-009 AN  output  8  anode select, active-low one-hot or all-ones.
REQ-010 SEG  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 DP  output  1  decimal-point cathode, active-low.
REQ-012 frame_done  output  1  one-clock pulse at end of each full scan frame.

Function
REQ-013 The FSM SHALL have exactly two states: BLANK and DRIVE; it SHALL also hold a digit index idx (0..NUM_DIGITS-1) and a cycle counter.
- BLANK: lasts BLANK_CYCLES clocks, then DRIVE with counter cleared; if BLANK_CYCLES = 0, BLANK is never entered.
- DRIVE: lasts DRIVE_CYCLES clocks, then idx advances and the FSM enters BLANK (or DRIVE if BLANK_CYCLES = 0).
REQ-014 idx SHALL wrap from NUM_DIGITS-1 to 0; digits >= NUM_DIGITS SHALL never be selected and their AN bits SHALL stay 1.
REQ-015 Frame length SHALL be exactly NUM_DIGITS*(BLANK_CYCLES+DRIVE_CYCLES) clocks.
REQ-016 AN, SEG, DP SHALL be registered outputs, changing only on clk edges (glitch-free), and SHALL reflect the current state/idx in the same cycle the state register holds it.
REQ-017 In BLANK: AN = 8'hFF, SEG = 7'h7F, DP = 1.
REQ-018 In DRIVE with digit_en[idx] = 1: AN bit idx = 0, all other bits 1; SEG = hex decode of shadow nibble idx; DP = ~shadow dp bit idx.
REQ-019 In DRIVE with digit_en[idx] = 0: AN = 8'hFF, SEG = 7'h7F, DP = 1; timing SHALL be unchanged (slot still consumed).
REQ-020 digit_en SHALL be sampled live each cycle (not shadowed).
REQ-021 Hex decode (SEG, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 A 32-bit digit shadow register and an 8-bit dp shadow register SHALL load digits_in and dp_in on the last DRIVE cycle of digit NUM_DIGITS-1 only; input changes mid-frame SHALL NOT affect the current frame.
REQ-023 frame_done SHALL be 1 for exactly the clock following that last DRIVE cycle (the first cycle of the new frame), 0 otherwise.
REQ-024 Counters SHALL be sized ceil(log2(max(DRIVE_CYCLES,BLANK_CYCLES)+1)) bits minimum; no overflow at any legal parameter value.

Reset
REQ-025 While rst = 1, and immediately on its assertion regardless of clk: AN = 8'hFF, SEG = 7'h7F, DP = 1, frame_done = 0, idx = 0, counter = 0, both shadow registers = 0.
REQ-026 State after reset release: BLANK (or DRIVE if BLANK_CYCLES = 0) at idx 0; first frame SHALL display 0 on every enabled digit with DP off.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse and no shadow load.

Verification
REQ-028 NUM_DIGITS=4, DRIVE=4, BLANK=2, digit_en=8'hFF -> AN sequence per digit: FF x2, then FE/FD/FB/F7 x4 each; frame_done pulses every 24 clocks.
REQ-029 Same config, digits_in=32'h0000_A810 held over frame boundary -> second frame SEG: digit0 1000000, digit1 1111001, digit2 0000000, digit3 0001000.
REQ-030 digits_in changed mid-frame 1 -> SEG unchanged until frame 2 starts; frame_done aligns with first new-value frame.
REQ-031 digit_en=8'b0000_0101 -> AN stays FF during digit 1 and 3 slots, frame still 24 clocks.
REQ-032 rst pulsed asynchronously during DRIVE of digit 2 -> AN=FF, SEG=7F same instant; after release scan restarts at digit 0 showing 0, first frame_done 24 clocks later.
REQ-033 BLANK=0, NUM_DIGITS=1, DRIVE=1 -> AN constantly FE (if enabled), frame_done high every cycle after the first.
